data_mem_responder: RTL

Data-memory responder for the RV32I multicycle core: the bus-side counterpart to the core's control unit. Accepts one load or store request at a time on the core data bus and performs byte/half/word stores with lane masking. Performs byte/half/word loads with sign or zero extension, then returns a ready/response handshake. Sits between the core's bus port and an internal synchronous word-organised RAM array.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/data_mem_responder_lsu_lane_align.sv | 56 +++++
 rtl/data_mem_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder and its lane aligner.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam logic LS_SIGNED   = 1'b0;
  localparam logic LS_UNSIGNED = 1'b1;

  // Size 2'b11 behaves as a word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    if (size == LS_BYTE) return 1'b0;
    if (size == LS_HALF) return off[0];
    return off != 2'b00;
  endfunction

endpackage

// File: rtl/data_mem_responder_lsu_lane_align.sv
// Combinational lane aligner: store byte-enables/replicated data and load lane select + extension.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sign,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        ext_neg;

  // Data is replicated across lanes so the byte-enables alone pick the destination.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      LS_BYTE: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_data[7:0]}};
      end
      LS_HALF: begin
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ld_word[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    ext_neg  = 1'b0;
    ld_data  = ld_word;
    case (ld_size)
      LS_BYTE: begin
        ext_neg = (ld_sign == LS_SIGNED) & byte_sel[7];
        ld_data = {{24{ext_neg}}, byte_sel};
      end
      LS_HALF: begin
        ext_neg = (ld_sign == LS_SIGNED) & half_sel[15];
        ld_data = {{16{ext_neg}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Bus-side load/store responder with internal word RAM; define MISALIGN_TRAP_EN to flag
// misaligned half/word accesses on busErr instead of silently aligning them.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busReq,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  input  logic [1:0]  LSControl,
  input  logic        SignControl,
  output logic [31:0] busRData,
  output logic        busReady,
  output logic        busErr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  mem_state_e            state;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [1:0]            off_q, size_q;
  logic                  sign_q, err_q;

  logic [ADDR_WIDTH-1:0] idx_in;
  logic                  mis_in, accept, wr_en;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata, ld_data, rd_word;
  logic                  unused_addr;

  assign idx_in      = busAddr[ADDR_WIDTH+1:2];
  assign unused_addr = ^busAddr[31:ADDR_WIDTH+2];
  assign accept      = reset && (state == IDLE) && busReq;
  assign rd_word     = mem[idx_q];

`ifdef MISALIGN_TRAP_EN
  assign mis_in = misaligned(LSControl, busAddr[1:0]);
`else
  assign mis_in = 1'b0;
`endif

  assign wr_en = accept && busWe && !mis_in;

  lsu_lane_align u_align (
    .st_size (LSControl),
    .st_off  (busAddr[1:0]),
    .st_data (busWData),
    .st_be   (st_be),
    .st_wdata(st_wdata),
    .ld_size (size_q),
    .ld_off  (off_q),
    .ld_sign (sign_q),
    .ld_word (rd_word),
    .ld_data (ld_data)
  );

  // Stores commit at the accept edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) mem[idx_in][8*b +: 8] <= st_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busReady <= 1'b0;
      busErr   <= 1'b0;
      busRData <= '0;
    end else begin
      case (state)
        IDLE: begin
          busReady <= 1'b0;
          busErr   <= 1'b0;
          busRData <= '0;
          if (busReq) begin
            idx_q  <= idx_in;
            off_q  <= busAddr[1:0];
            size_q <= LSControl;
            sign_q <= SignControl;
            err_q  <= mis_in;
            if (busWe) begin
              state    <= RESP;
              busReady <= 1'b1;
              busErr   <= mis_in;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          state    <= RESP;
          busReady <= 1'b1;
          busErr   <= err_q;
          busRData <= err_q ? '0 : ld_data;
        end
        RESP: begin
          state    <= IDLE;
          busReady <= 1'b0;
          busErr   <= 1'b0;
          busRData <= '0;
        end
        default: begin
          state    <= IDLE;
          busReady <= 1'b0;
          busErr   <= 1'b0;
          busRData <= '0;
        end
      endcase
    end
  end

endmodule
